axi_dma_twod_req_issuer: RTL and testbench

// - Request initiator on the DMA backend's 1D burst-request interface.
// - Sits between the DMA frontend and the AXI DMA backend.
// - Accepts one 2D job: src, dst, num_bytes, src_stride, dst_stride, num_reps.
// - Emits num_reps 1D burst requests to the backend, then tracks backend completions.
// - Pulses twod_done_o when every burst of the job has completed.

---
 rtl/axi_dma_twod_req_issuer_pkg.sv | 39 +++
 rtl/axi_dma_twod_req_issuer_if.sv | 27 ++
 rtl/axi_dma_outst_cnt.sv | 45 ++++
 rtl/axi_dma_twod_req_issuer.sv | 101 ++++++++++
 tb/tb_axi_dma_twod_req_issuer.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_dma_twod_req_issuer_pkg.sv
// Shared types and sizing for the 2D request issuer.
// Holds the 2D job descriptor, the backend burst request type, the FSM state type
// and the outstanding-counter width. No ports.
package axi_dma_twod_pkg;

  localparam int unsigned AddrWidth   = 64;
  localparam int unsigned LenWidth    = 32;
  localparam int unsigned RepWidth    = 32;
  // Largest outstanding limit the counter is sized for; instances may use less.
  localparam int unsigned MaxOutstCap = 16;
  localparam int unsigned OutstW      = $clog2(MaxOutstCap + 1);

  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [LenWidth-1:0]  len_t;
  typedef logic [RepWidth-1:0]  rep_t;

  typedef struct packed {
    addr_t src;
    addr_t dst;
    len_t  num_bytes;
    addr_t src_stride;
    addr_t dst_stride;
    rep_t  num_reps;
  } twod_req_t;

  // Same layout as the backend's 1D burst request.
  typedef struct packed {
    addr_t src;
    addr_t dst;
    len_t  num_bytes;
  } burst_req_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain
  } state_e;

endpackage

// File: rtl/axi_dma_twod_req_issuer_if.sv
// Frontend/backend handshake bundle of the 2D request issuer.
// master: the issuer (drives twod_ready, burst_req/valid, twod_done, busy).
// slave : the frontend/backend side (drives twod_req/valid, burst_ready, trans_complete).
interface axi_dma_twod_req_issuer_if;
  import axi_dma_twod_pkg::*;

  twod_req_t  twod_req;
  logic       twod_valid;
  logic       twod_ready;
  burst_req_t burst_req;
  logic       burst_valid;
  logic       burst_ready;
  logic       trans_complete;
  logic       twod_done;
  logic       busy;

  modport master (
    input  twod_req, twod_valid, burst_ready, trans_complete,
    output twod_ready, burst_req, burst_valid, twod_done, busy
  );

  modport slave (
    output twod_req, twod_valid, burst_ready, trans_complete,
    input  twod_ready, burst_req, burst_valid, twod_done, busy
  );

endinterface

// File: rtl/axi_dma_outst_cnt.sv
// Up/down saturating counter of bursts issued but not yet completed.
// Ports: clk_i, rst_ni (async, active-low); inc_i (burst handshake); dec_i (completion);
// full_o / empty_o describe the count as it will be after this cycle's update, so the
// issuer can register its valid and done outputs without an extra cycle of latency.
// MaxOutst must not exceed MaxOutstCap.
module axi_dma_outst_cnt
  import axi_dma_twod_pkg::*;
#(
  parameter int unsigned MaxOutst = MaxOutstCap
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic empty_o
);

  logic [OutstW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    case ({inc_i, dec_i})
      2'b10: if (cnt_q != OutstW'(MaxOutst)) cnt_d = cnt_q + OutstW'(1);
      // A completion with nothing outstanding is illegal; hold at zero.
      2'b01: if (cnt_q != '0) cnt_d = cnt_q - OutstW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign full_o  = (cnt_d == OutstW'(MaxOutst));
  assign empty_o = (cnt_d == '0);

  underflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (dec_i && !inc_i) |-> (cnt_q != '0));

endmodule

// File: rtl/axi_dma_twod_req_issuer.sv
// 2D request issuer: turns one 2D job into num_reps 1D burst requests for the DMA backend,
// tracks backend completions and pulses twod_done once every burst of the job has finished.
// Ports: clk_i, rst_ni (async, active-low); bus (master modport): twod_req/valid/ready job
// handshake, burst_req/valid/ready burst handshake, trans_complete from the backend,
// twod_done completion pulse, busy while a job is in progress.
module axi_dma_twod_req_issuer
  import axi_dma_twod_pkg::*;
#(
  parameter int unsigned MaxOutst = MaxOutstCap
) (
  input logic                        clk_i,
  input logic                        rst_ni,
  axi_dma_twod_req_issuer_if.master  bus
);

  state_e state_q;
  addr_t  src_q, dst_q, src_stride_q, dst_stride_q;
  len_t   num_bytes_q;
  rep_t   rep_cnt_q;
  logic   burst_valid_q, twod_done_q;
  logic   burst_hs, outst_full, outst_empty;

  assign burst_hs = burst_valid_q && bus.burst_ready;

  axi_dma_outst_cnt #(
    .MaxOutst (MaxOutst)
  ) u_outst_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (burst_hs),
    .dec_i   (bus.trans_complete),
    .full_o  (outst_full),
    .empty_o (outst_empty)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      src_q         <= '0;
      dst_q         <= '0;
      src_stride_q  <= '0;
      dst_stride_q  <= '0;
      num_bytes_q   <= '0;
      rep_cnt_q     <= '0;
      burst_valid_q <= 1'b0;
      twod_done_q   <= 1'b0;
    end else begin
      twod_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.twod_valid) begin
            if (bus.twod_req.num_reps != '0) begin
              src_q         <= bus.twod_req.src;
              dst_q         <= bus.twod_req.dst;
              src_stride_q  <= bus.twod_req.src_stride;
              dst_stride_q  <= bus.twod_req.dst_stride;
              num_bytes_q   <= bus.twod_req.num_bytes;
              rep_cnt_q     <= bus.twod_req.num_reps;
              burst_valid_q <= 1'b1;
              state_q       <= StIssue;
            end else begin
              // Empty job: nothing to issue, report completion right away.
              twod_done_q <= 1'b1;
            end
          end
        end
        StIssue: begin
          if (burst_hs) begin
            // Strides wrap modulo 2^AddrWidth, so negative strides work as two's complement.
            src_q     <= src_q + src_stride_q;
            dst_q     <= dst_q + dst_stride_q;
            rep_cnt_q <= rep_cnt_q - RepWidth'(1);
            if (rep_cnt_q == RepWidth'(1)) begin
              burst_valid_q <= 1'b0;
              state_q       <= StDrain;
            end else begin
              burst_valid_q <= !outst_full;
            end
          end else if (!burst_valid_q) begin
            // Only re-present once a slot frees up; a presented request is never withdrawn.
            burst_valid_q <= !outst_full;
          end
        end
        StDrain: begin
          if (outst_empty) begin
            twod_done_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.twod_ready  = (state_q == StIdle);
  assign bus.burst_req   = '{src: src_q, dst: dst_q, num_bytes: num_bytes_q};
  assign bus.burst_valid = burst_valid_q;
  assign bus.twod_done   = twod_done_q;
  assign bus.busy        = (state_q != StIdle);

endmodule

// File: tb/tb_axi_dma_twod_req_issuer.sv
// Self-checking bench for the 2D request issuer. Expected bursts and per-job burst counts are
// queued when a job is issued; a monitor pops and compares whenever the DUT hands over a
// burst or pulses done. A small backend model completes each burst one cycle after it is
// accepted, unless completions are being withheld.
module tb_axi_dma_twod_req_issuer;
  import axi_dma_twod_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_dma_twod_req_issuer_if bus ();

  axi_dma_twod_req_issuer #(
    .MaxOutst (2)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int total = 0;
  int bad = 0;
  burst_req_t exp_q[$];
  int done_q[$];
  int hs_cyc_q[$];
  int cyc = 0;
  int acc_cyc = 0;
  int last_tc_cyc = -10;
  int done_cyc = -10;
  int done_cnt = 0;
  int hs_cnt = 0;
  int bursts_in_job = 0;
  int ready_mode = 1;   // 0: low, 1: high, 2: random 30%
  bit hold = 1'b0;      // withhold completions
  int grant = 0;        // completions released while holding
  int pending = 0;
  burst_req_t prev_req;
  bit prev_stall = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic exp_burst(input addr_t s, input addr_t d, input len_t n);
    exp_q.push_back('{src: s, dst: d, num_bytes: n});
  endtask

  function automatic twod_req_t mk_req(input addr_t s, input addr_t d, input len_t n,
                                       input addr_t ss, input addr_t ds, input rep_t reps);
    return '{src: s, dst: d, num_bytes: n, src_stride: ss, dst_stride: ds, num_reps: reps};
  endfunction

  task automatic issue(input twod_req_t r);
    int b = 0;
    @(posedge clk);
    #1;
    bus.twod_req = r;
    bus.twod_valid = 1'b1;
    @(negedge clk);
    while (!bus.twod_ready && b < 100) begin
      @(negedge clk);
      b++;
    end
    if (!bus.twod_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: ready=%0b want 1", bus.twod_ready);
    end
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    bus.twod_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    int b = 0;
    while (done_cnt < target && b < 1000) begin
      @(posedge clk);
      b++;
    end
    check({name, "_done_seen"}, 64'(done_cnt), 64'(target));
  endtask

  // Monitor / scoreboard.
  initial begin
    forever begin
      burst_req_t e;
      int er;
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        bursts_in_job = 0;
      end else begin
        if (prev_stall) begin
          total++;
          if (!bus.burst_valid || bus.burst_req != prev_req) begin
            bad++;
            $display("FAIL stall_stable: got valid=%0b req=%h want valid=1 req=%h",
                     bus.burst_valid, bus.burst_req, prev_req);
          end
        end
        prev_stall = bus.burst_valid && !bus.burst_ready;
        prev_req = bus.burst_req;
        if (bus.burst_valid && bus.burst_ready) begin
          hs_cnt++;
          bursts_in_job++;
          hs_cyc_q.push_back(cyc);
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL burst_unexpected: got %h want none", bus.burst_req);
          end else begin
            e = exp_q.pop_front();
            if (bus.burst_req != e) begin
              bad++;
              $display("FAIL burst: got %h want %h", bus.burst_req, e);
            end
          end
        end
        if (bus.trans_complete) last_tc_cyc = cyc;
        if (bus.twod_done) begin
          done_cnt++;
          done_cyc = cyc;
          total++;
          if (done_q.size() == 0) begin
            bad++;
            $display("FAIL done_unexpected: got done=1 want 0");
          end else begin
            er = done_q.pop_front();
            if (bursts_in_job != er) begin
              bad++;
              $display("FAIL done_bursts: got %0d bursts want %0d", bursts_in_job, er);
            end
          end
          bursts_in_job = 0;
        end
      end
    end
  end

  // Backend model: completion one cycle after acceptance; drives burst_ready.
  initial begin
    bus.burst_ready = 1'b1;
    bus.trans_complete = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.burst_valid && bus.burst_ready) pending++;
      @(posedge clk);
      #2;
      if (!rst_n) pending = 0;
      if (rst_n && pending > 0 && (!hold || grant > 0)) begin
        bus.trans_complete = 1'b1;
        pending--;
        if (hold) grant--;
      end else begin
        bus.trans_complete = 1'b0;
      end
      case (ready_mode)
        0:       bus.burst_ready = 1'b0;
        1:       bus.burst_ready = 1'b1;
        default: bus.burst_ready = ($urandom_range(0, 99) < 30);
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base;
    int b;
    int dc;
    bus.twod_valid = 1'b0;
    bus.twod_req = '0;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_burst_valid", 64'(bus.burst_valid), 64'd0);
    check("rst_twod_done", 64'(bus.twod_done), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 64'(bus.twod_ready), 64'd1);

    // Single job, ready always high: four back-to-back bursts.
    hs_cyc_q.delete();
    exp_burst(64'h1000, 64'h8000, 32'd64);
    exp_burst(64'h1100, 64'h8040, 32'd64);
    exp_burst(64'h1200, 64'h8080, 32'd64);
    exp_burst(64'h1300, 64'h80C0, 32'd64);
    done_q.push_back(4);
    issue(mk_req(64'h1000, 64'h8000, 32'd64, 64'h100, 64'h40, 32'd4));
    @(negedge clk);
    check("job1_busy", 64'(bus.busy), 64'd1);
    wait_done(1, "job1");
    check("job1_hs_count", 64'(hs_cyc_q.size()), 64'd4);
    if (hs_cyc_q.size() == 4) begin
      check("job1_first_lat", 64'(hs_cyc_q[0]), 64'(acc_cyc + 1));
      check("job1_back2back", 64'(hs_cyc_q[3]), 64'(acc_cyc + 4));
    end
    check("job1_done_lat", 64'(done_cyc), 64'(last_tc_cyc + 1));

    // Random backpressure.
    ready_mode = 2;
    exp_burst(64'h4000, 64'h5000, 32'd32);
    exp_burst(64'h4020, 64'h5080, 32'd32);
    exp_burst(64'h4040, 64'h5100, 32'd32);
    exp_burst(64'h4060, 64'h5180, 32'd32);
    exp_burst(64'h4080, 64'h5200, 32'd32);
    done_q.push_back(5);
    base = hs_cnt;
    issue(mk_req(64'h4000, 64'h5000, 32'd32, 64'h20, 64'h80, 32'd5));
    wait_done(2, "bp");
    ready_mode = 1;
    check("bp_hs_count", 64'(hs_cnt - base), 64'd5);

    // Zero reps: immediate done, no bursts, never busy.
    done_q.push_back(0);
    base = hs_cnt;
    issue(mk_req(64'h9000, 64'h9100, 32'd8, 64'h10, 64'h10, 32'd0));
    @(negedge clk);
    check("zero_busy", 64'(bus.busy), 64'd0);
    wait_done(3, "zero");
    check("zero_done_lat", 64'(done_cyc), 64'(acc_cyc + 1));
    check("zero_no_burst", 64'(hs_cnt - base), 64'd0);

    // Address wrap and negative destination stride.
    exp_burst(64'hFFFF_FFFF_FFFF_FFC0, 64'h100, 32'h40);
    exp_burst(64'h0, 64'hC0, 32'h40);
    done_q.push_back(2);
    issue(mk_req(64'hFFFF_FFFF_FFFF_FFC0, 64'h100, 32'h40, 64'h40,
                 64'hFFFF_FFFF_FFFF_FFC0, 32'd2));
    wait_done(4, "wrap");

    // Outstanding limit of 2 with completions withheld.
    hold = 1'b1;
    grant = 0;
    exp_burst(64'h2000, 64'h3000, 32'd16);
    exp_burst(64'h2010, 64'h3010, 32'd16);
    exp_burst(64'h2020, 64'h3020, 32'd16);
    exp_burst(64'h2030, 64'h3030, 32'd16);
    done_q.push_back(4);
    base = hs_cnt;
    issue(mk_req(64'h2000, 64'h3000, 32'd16, 64'h10, 64'h10, 32'd4));
    repeat (8) @(posedge clk);
    #1;
    check("outst_full_count", 64'(hs_cnt - base), 64'd2);
    check("outst_full_valid", 64'(bus.burst_valid), 64'd0);
    grant = 1;
    repeat (6) @(posedge clk);
    #1;
    check("outst_one_freed", 64'(hs_cnt - base), 64'd3);
    check("outst_refull_valid", 64'(bus.burst_valid), 64'd0);
    hold = 1'b0;
    wait_done(5, "outst");

    // Reset in the middle of issuing after 2 of 8 reps.
    for (int i = 0; i < 8; i++) begin
      exp_burst(64'h6000 + 64'(i * 16), 64'h7000 + 64'(i * 16), 32'd16);
    end
    done_q.push_back(8);
    base = hs_cnt;
    issue(mk_req(64'h6000, 64'h7000, 32'd16, 64'h10, 64'h10, 32'd8));
    b = 0;
    while (hs_cnt < base + 2 && b < 100) begin
      @(posedge clk);
      b++;
    end
    check("rst_mid_reached", 64'(hs_cnt - base), 64'd2);
    #1;
    ready_mode = 0;
    rst_n = 1'b0;
    exp_q.delete();
    done_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("rst_mid_valid_in_rst", 64'(bus.burst_valid), 64'd0);
    rst_n = 1'b1;
    ready_mode = 1;
    @(negedge clk);
    check("rst_mid_valid", 64'(bus.burst_valid), 64'd0);
    check("rst_mid_ready", 64'(bus.twod_ready), 64'd1);
    check("rst_mid_busy", 64'(bus.busy), 64'd0);
    dc = done_cnt;
    repeat (10) @(posedge clk);
    #1;
    check("rst_mid_no_done", 64'(done_cnt), 64'(dc));

    // A new job after the abort completes normally.
    exp_burst(64'hA000, 64'hB000, 32'd8);
    exp_burst(64'hA008, 64'hB008, 32'd8);
    done_q.push_back(2);
    issue(mk_req(64'hA000, 64'hB000, 32'd8, 64'h8, 64'h8, 32'd2));
    wait_done(dc + 1, "post_rst");

    repeat (3) @(posedge clk);
    #1;
    check("leftover_bursts", 64'(exp_q.size()), 64'd0);
    check("leftover_dones", 64'(done_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
